instr_sequencer: RTL

- Parametrised fetch/issue controller; successor to the fixed 16-bit, single-latency top-level sequencer.
- Owns the PC and fetches from instruction memory with configurable read latency.
- Issues non-branch instructions to the execution core with a start/done handshake, and resolves branches and halt internally.
- Sits between instruction memory and the core; generalises data width, address width, memory latency and reset vector.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_branch_unit.sv | 39 +++
 rtl/instr_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, opcode class
// and branch condition codes.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        UPDATE = 3'd5,
        HALT   = 3'd6
    } seq_state_e;

    localparam logic [1:0] BR_CLASS = 2'b10;

    localparam logic [1:0] COND_EQZ = 2'b00;
    localparam logic [1:0] COND_NEZ = 2'b01;
    localparam logic [1:0] COND_NEG = 2'b10;
    localparam logic [1:0] COND_ALW = 2'b11;

endpackage

// File: rtl/seq_branch_unit.sv
// Combinational next-PC resolver: evaluates branch condition against the last
// retired result and selects target or pc+1 (wrapping).
module seq_branch_unit
    import seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] last_result,
    output logic [ADDR_W-1:0] next_pc
);

    logic              is_branch;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_instr_bits;

    assign is_branch         = (instr[1:0] == BR_CLASS);
    assign target            = instr[ADDR_W+3:4];
    assign pc_inc            = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign unused_instr_bits = ^instr;

    always_comb begin
        taken = 1'b0;
        case (instr[3:2])
            COND_EQZ: taken = (last_result == '0);
            COND_NEZ: taken = (last_result != '0);
            COND_NEG: taken = last_result[DATA_W-1];
            COND_ALW: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

    assign next_pc = (is_branch && taken) ? target : pc_inc;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: owns the PC, fetches with MEM_LAT read latency, issues
// non-branch instructions to the core. SEQ_RETIRE_CNT_EN adds a retire counter.
//
// state  | meaning
// IDLE   | after reset, waiting for run
// FETCH  | counting memory latency, then capture instruction
// DECODE | classify: halt, branch or core instruction
// ISSUE  | core_start pulse (only while run)
// WAIT   | waiting for core_done (flag latches even with run low)
// UPDATE | load next_pc
// HALT   | terminal until reset
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_start,
    output logic [DATA_W-1:0] core_instr,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] last_result,
    output logic              halted
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam logic [2:0]        LAT_LAST = 3'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] core_instr_q, core_instr_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;
    logic [DATA_W-1:0] done_result_q, done_result_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] next_pc;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0]       retired_q, retired_d;
`endif

    seq_branch_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_branch (
        .pc          (pc_q),
        .instr       (instr_q),
        .last_result (last_result_q),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= PC_INIT;
            instr_q       <= '0;
            core_instr_q  <= '0;
            last_result_q <= '0;
            done_result_q <= '0;
            lat_cnt_q     <= '0;
            done_q        <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
            retired_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            core_instr_q  <= core_instr_d;
            last_result_q <= last_result_d;
            done_result_q <= done_result_d;
            lat_cnt_q     <= lat_cnt_d;
            done_q        <= done_d;
`ifdef SEQ_RETIRE_CNT_EN
            retired_q     <= retired_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        core_instr_d  = core_instr_q;
        last_result_d = last_result_q;
        done_result_d = done_result_q;
        lat_cnt_d     = lat_cnt_q;
        done_d        = done_q;
`ifdef SEQ_RETIRE_CNT_EN
        retired_d     = retired_q;
`endif

        // The core may finish while we are stalled; keep the first result.
        if (state_q == WAIT && core_done && !done_q) begin
            done_d        = 1'b1;
            done_result_d = core_result;
        end

        if (run) begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        instr_d   = mem_rdata;
                        lat_cnt_d = '0;
                        state_d   = DECODE;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 3'd1;
                    end
                end
                DECODE: begin
                    if (&instr_q) begin
                        state_d = HALT;
                    end else if (instr_q[1:0] == BR_CLASS) begin
                        state_d = UPDATE;
                    end else begin
                        core_instr_d = instr_q;
                        state_d      = ISSUE;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (done_q) begin
                        last_result_d = done_result_q;
                        done_d        = 1'b0;
                        state_d       = UPDATE;
                    end
                end
                UPDATE: begin
                    pc_d    = next_pc;
                    state_d = FETCH;
`ifdef SEQ_RETIRE_CNT_EN
                    retired_d = retired_q + 32'd1;
`endif
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    assign core_start  = (state_q == ISSUE) && run;
    assign halted      = (state_q == HALT);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign core_instr  = core_instr_q;
    assign last_result = last_result_q;
`ifdef SEQ_RETIRE_CNT_EN
    assign retired     = retired_q;
`endif

endmodule
